fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the pipelined MIPS datapath. Owns the PC and drives ADDR into the byte-addressed, big-endian, combinational instruction memory, which returns the 32-bit word on INS in the same cycle. Captures INS and PC+4 into the IF/ID pipeline register and handles stall, flush and taken-branch redirects from later stages.

Parameters:
MEM_BYTES, 400, size of instruction memory in bytes; the PC wraps within it.
RESET_PC, 0, PC value loaded on reset; must be a multiple of 4.

Ports:
CLK  in  1  system clock, all state updates on the rising edge
RST_N  in  1  asynchronous, active-low reset
STALL  in  1  hold the PC and the IF/ID register (load-use hazard)
FLUSH  in  1  turn the IF/ID content into a bubble on the next edge
BR_TAKEN  in  1  redirect the PC to BR_TARGET
BR_TARGET  in  32  branch/jump byte address
ADDR  out  32  instruction address to memory; equals PC combinationally
INS  in  32  instruction word returned by memory for ADDR
IFID_INS  out  32  latched instruction
IFID_PC4  out  32  latched PC+4 of that instruction
IFID_VALID  out  1  IF/ID holds a real instruction
ADDR_ERR  out  1  sticky flag: a redirect target was out of range
HALTED  out  1  fetch halted; only meaningful with the optional feature

Behaviour:
- Reset (RST_N=0, asynchronous): PC=RESET_PC, IFID_INS=0, IFID_PC4=0, IFID_VALID=0, ADDR_ERR=0, HALTED=0, FSM=RUN. Reset overrides all other inputs at any time, including mid-stall.
- FSM states: RUN and HALT. HALT exists only with the macro. Without the macro the FSM is always RUN.
- pc_inc = PC+4. If pc_inc >= MEM_BYTES, pc_inc = 0 (wrap-around).
- Redirect target = {BR_TARGET[31:2],2'b00}. Misaligned low bits are silently dropped.
- Out-of-range target (aligned target > MEM_BYTES-4): PC=RESET_PC, ADDR_ERR set to 1 and held until reset.
- Per rising edge, in priority order:
  1. BR_TAKEN=1: PC=target. IF/ID gets a bubble (IFID_INS=0, IFID_VALID=0, IFID_PC4 unchanged). STALL is ignored. Leaves HALT for RUN.
  2. FLUSH=1 (without BR_TAKEN): IF/ID gets a bubble. PC=pc_inc if STALL=0, otherwise PC holds.
  3. STALL=1: PC and all IF/ID outputs hold their values.
  4. Otherwise, in RUN: IFID_INS=INS, IFID_PC4=pc_inc before wrap (PC+4), IFID_VALID=1, PC=pc_inc.
- Latency: an instruction appears on IFID_* one edge after its address is on ADDR.
- After reset release, IFID_VALID stays 0 until the first non-stalled edge.
- ADDR never exceeds MEM_BYTES-4, so the memory's 4-byte read stays in bounds.

Optional Feature:
Macro FETCH_HALT_ON_ZERO_EN.
- Defined: in RUN, a non-stalled, non-flushed, non-redirect edge where INS == 32'h0 (the program end marker) moves the FSM to HALT. That zero word is still latched with IFID_VALID=1. In HALT: PC holds, IF/ID loads bubbles every edge, HALTED=1. Only BR_TAKEN or reset leaves HALT.
- Not defined: HALTED is tied to 0, INS==0 is treated as an ordinary NOP and fetched normally, and the FSM is always RUN.

Test Plan:
- Reset, then 3 free-running edges with memory returning words W0..W2 -> ADDR sequence 0,4,8,12; IFID_INS=W0,W1,W2; IFID_PC4=4,8,12; VALID goes 0 then 1.
- PC=8, STALL=1 for 2 edges -> ADDR stays 8, IFID_* unchanged; on release, PC=12 and the word at 8 is latched.
- PC=16, BR_TAKEN=1 with BR_TARGET=0x25 and STALL=1 -> PC=0x24, IFID_VALID=0, IFID_INS=0, ADDR_ERR=0.
- PC=396 (MEM_BYTES=400) -> next PC=0, IFID_PC4=400. Separately, BR_TARGET=400 -> PC=RESET_PC, ADDR_ERR=1 and sticky.
- FLUSH=1 alone at PC=20 -> PC=24, IFID_VALID=0. Assert RST_N=0 between clock edges -> all outputs are at reset values immediately.
- With FETCH_HALT_ON_ZERO_EN defined, INS=0 at PC=20 -> zero word latched valid, then HALTED=1 and ADDR holds 20; BR_TAKEN to 0 -> HALTED=0 and fetch resumes at 0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction
// memory and fills the IF/ID register. Optional halt-on-zero via FETCH_HALT_ON_ZERO_EN.
module fetch_stage #(
   parameter int          MEM_BYTES = 400,
   parameter logic [31:0] RESET_PC  = 32'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic [31:0] addr,
   input  logic [31:0] ins,
   output logic [31:0] ifid_ins,
   output logic [31:0] ifid_pc4,
   output logic        ifid_valid,
   output logic        addr_err,
   output logic        halted,
   output logic        state_dbg
);

   // ifid_valid qualifies ifid_ins/ifid_pc4 on every cycle; there is no ready,
   // downstream backpressure arrives only as stall, which freezes PC and IF/ID.

   localparam logic [31:0] MEM_SIZE  = 32'(MEM_BYTES);
   localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

`ifdef FETCH_HALT_ON_ZERO_EN
   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;
`else
   typedef enum logic {RUN = 1'b0} state_t;
`endif

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ins_q, ins_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;

   logic [31:0] pc_plus4;
   logic [31:0] pc_inc;
   logic [31:0] tgt;
   logic        tgt_bad;

   assign pc_plus4 = pc_q + 32'd4;
   assign pc_inc   = (pc_plus4 >= MEM_SIZE) ? 32'h0 : pc_plus4;
   assign tgt      = {br_target[31:2], 2'b00};
   assign tgt_bad  = (tgt > LAST_WORD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         ins_q   <= 32'h0;
         pc4_q   <= 32'h0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ins_q   <= ins_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ins_d   = ins_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      err_d   = err_q;
      if (br_taken) begin
         // Redirect wins over stall; an out-of-range target restarts at reset PC.
         pc_d    = tgt_bad ? RESET_PC : tgt;
         err_d   = err_q | tgt_bad;
         ins_d   = 32'h0;
         valid_d = 1'b0;
         state_d = RUN;
      end else if (flush) begin
         ins_d   = 32'h0;
         valid_d = 1'b0;
         if (!stall && state_q == RUN)
            pc_d = pc_inc;
      end else if (stall) begin
         pc_d = pc_q;
`ifdef FETCH_HALT_ON_ZERO_EN
      end else if (state_q == HALT) begin
         ins_d   = 32'h0;
         valid_d = 1'b0;
`endif
      end else begin
         ins_d   = ins;
         pc4_d   = pc_plus4;
         valid_d = 1'b1;
`ifdef FETCH_HALT_ON_ZERO_EN
         // The end marker is delivered once; the PC parks on its address.
         if (ins == 32'h0)
            state_d = HALT;
         else
            pc_d = pc_inc;
`else
         pc_d = pc_inc;
`endif
      end
   end

   assign addr       = pc_q;
   assign ifid_ins   = ins_q;
   assign ifid_pc4   = pc4_q;
   assign ifid_valid = valid_q;
   assign addr_err   = err_q;
   assign state_dbg  = state_q;

`ifdef FETCH_HALT_ON_ZERO_EN
   assign halted = (state_q == HALT);
`else
   assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, async-reset and halt sequences,
// then a randomized run checked through an expected-result queue.
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        flush;
   logic        br_taken;
   logic [31:0] br_target;
   logic [31:0] addr;
   logic [31:0] ins;
   logic [31:0] ifid_ins;
   logic [31:0] ifid_pc4;
   logic        ifid_valid;
   logic        addr_err;
   logic        halted;
   logic        state_dbg;

   logic [31:0] imem [0:127];

   int total;
   int bad;

   logic [97:0] exp_q[$];

   typedef struct {
      logic        st;
      logic        fl;
      logic        br;
      logic [31:0] tg;
      logic [31:0] e_addr;
      int          e_from;
      logic [31:0] e_pc4;
      logic        e_valid;
      logic        e_err;
   } vec_t;

   vec_t vt [16];

   fetch_stage #(.MEM_BYTES(400), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .br_taken(br_taken), .br_target(br_target), .addr(addr), .ins(ins),
      .ifid_ins(ifid_ins), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
      .addr_err(addr_err), .halted(halted), .state_dbg(state_dbg)
   );

   // clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb ins = imem[addr[8:2]];

   // driver tasks
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic f, input logic b, input logic [31:0] t);
      stall = s; flush = f; br_taken = b; br_target = t;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_addr"},  addr, 32'h0);
      check({tag, "_ins"},   ifid_ins, 32'h0);
      check({tag, "_pc4"},   ifid_pc4, 32'h0);
      check({tag, "_valid"}, {31'h0, ifid_valid}, 32'h0);
      check({tag, "_err"},   {31'h0, addr_err}, 32'h0);
      check({tag, "_halt"},  {31'h0, halted}, 32'h0);
      check({tag, "_state"}, {31'h0, state_dbg}, 32'h0);
   endtask

   logic [31:0] m_pc, m_ins, m_pc4, m_tgt, m_inc, m_incw;
   logic        m_valid, m_err, r_st, r_fl, r_br;
   logic [31:0] r_tg;
   logic [97:0] got, want;

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < 128; i++) imem[i] = $urandom() | 32'h1;
      rst_n = 1'b0;
      drive(0, 0, 0, 0);

      //           st fl br tgt     addr  from  pc4  v  err
      vt[0]  = '{0, 0, 0, 32'h0,   4,    0,    4,   1, 0};
      vt[1]  = '{0, 0, 0, 32'h0,   8,    4,    8,   1, 0};
      vt[2]  = '{1, 0, 0, 32'h0,   8,    4,    8,   1, 0};
      vt[3]  = '{1, 0, 0, 32'h0,   8,    4,    8,   1, 0};
      vt[4]  = '{0, 0, 0, 32'h0,   12,   8,    12,  1, 0};
      vt[5]  = '{0, 0, 0, 32'h0,   16,   12,   16,  1, 0};
      vt[6]  = '{1, 0, 1, 32'h25,  36,   -1,   16,  0, 0};
      vt[7]  = '{0, 0, 0, 32'h0,   40,   36,   40,  1, 0};
      vt[8]  = '{0, 1, 0, 32'h0,   44,   -1,   40,  0, 0};
      vt[9]  = '{1, 1, 0, 32'h0,   44,   -1,   40,  0, 0};
      vt[10] = '{0, 0, 1, 32'd396, 396,  -1,   40,  0, 0};
      vt[11] = '{0, 0, 0, 32'h0,   0,    396,  400, 1, 0};
      vt[12] = '{0, 0, 1, 32'd398, 396,  -1,   400, 0, 0};
      vt[13] = '{0, 0, 1, 32'd400, 0,    -1,   400, 0, 1};
      vt[14] = '{0, 0, 0, 32'h0,   4,    0,    4,   1, 1};
      vt[15] = '{0, 0, 1, 32'd20,  20,   -1,   4,   0, 1};

      do_reset();
      check_reset_vals("rst");

      for (int i = 0; i < 16; i++) begin
         logic [31:0] e_ins;
         e_ins = (vt[i].e_from < 0) ? 32'h0 : imem[vt[i].e_from / 4];
         drive(vt[i].st, vt[i].fl, vt[i].br, vt[i].tg);
         step();
         check($sformatf("v%0d_addr", i), addr, vt[i].e_addr);
         check($sformatf("v%0d_ins", i), ifid_ins, e_ins);
         check($sformatf("v%0d_pc4", i), ifid_pc4, vt[i].e_pc4);
         check($sformatf("v%0d_valid", i), {31'h0, ifid_valid}, {31'h0, vt[i].e_valid});
         check($sformatf("v%0d_err", i), {31'h0, addr_err}, {31'h0, vt[i].e_err});
      end

      // async reset between edges, including while stalled
      drive(1, 0, 0, 0);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_reset_vals("arst");
      step();
      check_reset_vals("arst_hold");
      rst_n = 1'b1;
      drive(0, 0, 0, 0);

      // randomized run against a reference model and expected queue
      do_reset();
      m_pc = 0; m_ins = 0; m_pc4 = 0; m_valid = 0; m_err = 0;
      for (int c = 0; c < 400; c++) begin
         r_st = ($urandom_range(0, 3) == 0);
         r_fl = ($urandom_range(0, 9) == 0);
         r_br = ($urandom_range(0, 9) == 0);
         r_tg = 32'($urandom_range(0, 420));
         m_tgt  = {r_tg[31:2], 2'b00};
         m_inc  = m_pc + 4;
         m_incw = (m_inc >= 400) ? 32'h0 : m_inc;
         if (r_br) begin
            m_err   = m_err | (m_tgt > 396);
            m_pc    = (m_tgt > 396) ? 32'h0 : m_tgt;
            m_ins   = 0;
            m_valid = 0;
         end else if (r_fl) begin
            m_ins   = 0;
            m_valid = 0;
            if (!r_st) m_pc = m_incw;
         end else if (!r_st) begin
            m_ins   = imem[m_pc[8:2]];
            m_pc4   = m_inc;
            m_valid = 1;
            m_pc    = m_incw;
         end
         exp_q.push_back({m_pc, m_ins, m_pc4, m_valid, m_err});
         drive(r_st, r_fl, r_br, r_tg);
         step();
         want = exp_q.pop_front();
         got  = {addr, ifid_ins, ifid_pc4, ifid_valid, addr_err};
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL rand_c%0d: got %h want %h", c, got, want);
         end
      end
      drive(0, 0, 0, 0);

      // end-marker word at address 20
      imem[5] = 32'h0;
      do_reset();
      repeat (5) step();
      check("z_addr20", addr, 32'd20);
`ifdef FETCH_HALT_ON_ZERO_EN
      step();
      check("h_ins", ifid_ins, 32'h0);
      check("h_valid", {31'h0, ifid_valid}, 32'h1);
      check("h_halted", {31'h0, halted}, 32'h1);
      check("h_addr", addr, 32'd20);
      step();
      check("h2_valid", {31'h0, ifid_valid}, 32'h0);
      check("h2_addr", addr, 32'd20);
      check("h2_halted", {31'h0, halted}, 32'h1);
      check("h2_state", {31'h0, state_dbg}, 32'h1);
      drive(0, 0, 1, 32'h0);
      step();
      check("h3_addr", addr, 32'h0);
      check("h3_halted", {31'h0, halted}, 32'h0);
      drive(0, 0, 0, 0);
      step();
      check("h4_addr", addr, 32'd4);
      check("h4_ins", ifid_ins, imem[0]);
      check("h4_valid", {31'h0, ifid_valid}, 32'h1);
`else
      step();
      check("z_ins", ifid_ins, 32'h0);
      check("z_valid", {31'h0, ifid_valid}, 32'h1);
      check("z_addr", addr, 32'd24);
      check("z_halted", {31'h0, halted}, 32'h0);
      step();
      check("z2_ins", ifid_ins, imem[6]);
      check("z2_addr", addr, 32'd28);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
